// File: rtl/fp_issue_ctrl.sv
// Issue/writeback controller between the FP decoder and a handshaked FPU.
// Keeps one operation in flight: IDLE -> ISSUE -> EXEC -> WB, or EXEC -> IDLE on timeout.
module fp_issue_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            dec_valid_i,
  input  logic            dec_illegal_i,
  input  logic            dec_regwrite_i,
  input  logic [4:0]      dec_rd_i,
  output logic            dec_ready_o,
  output logic            fpu_in_valid_o,
  input  logic            fpu_in_ready_i,
  input  logic            fpu_out_valid_i,
  output logic            fpu_out_ready_o,
  input  logic [XLEN-1:0] fpu_result_i,
  input  logic [4:0]      fpu_status_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            int_wb_valid_o,
  output logic [XLEN-1:0] int_wb_data_o,
  output logic [4:0]      fflags_o,
  input  logic            fflags_clr_i,
  output logic            illegal_o,
  output logic            timeout_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_e;

  // EXEC lasts at most TIMEOUT cycles; the counter holds 0..TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [4:0]      rd_q, rd_d;
  logic            regwrite_q, regwrite_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      status_q, status_d;
  logic [4:0]      fflags_q, fflags_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      rd_q       <= 5'd0;
      regwrite_q <= 1'b0;
      result_q   <= {XLEN{1'b0}};
      status_q   <= 5'd0;
      fflags_q   <= 5'd0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      result_q   <= result_d;
      status_q   <= status_d;
      fflags_q   <= fflags_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next-state, capture and sticky-flag logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = 8'd0;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    result_d   = result_q;
    status_d   = status_q;
    illegal_d  = 1'b0;
    timeout_d  = 1'b0;
    fflags_d   = fflags_clr_i ? 5'd0 : fflags_q;
    case (state_q)
      IDLE: begin
        if (dec_valid_i) begin
          if (dec_illegal_i) begin
            illegal_d = 1'b1;
          end else begin
            rd_d       = dec_rd_i;
            regwrite_d = dec_regwrite_i;
            state_d    = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (fpu_in_ready_i) begin
          state_d = EXEC;
        end else begin
          state_d = ISSUE;
        end
      end
      EXEC: begin
        // A result arriving on the last allowed cycle still wins over the abort.
        if (fpu_out_valid_i) begin
          result_d = fpu_result_i;
          status_d = fpu_status_i;
          state_d  = WB;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB: begin
        fflags_d = fflags_clr_i ? status_q : (fflags_q | status_q);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dec_ready_o     = rst_ni & (state_q == IDLE);
  assign fpu_in_valid_o  = (state_q == ISSUE);
  assign fpu_out_ready_o = (state_q == EXEC);
  assign busy_o          = (state_q != IDLE);

  assign rf_we_o        = (state_q == WB) & regwrite_q;
  assign rf_waddr_o     = rf_we_o ? rd_q : 5'd0;
  assign rf_wdata_o     = rf_we_o ? result_q : {XLEN{1'b0}};
  assign int_wb_valid_o = (state_q == WB) & ~regwrite_q;
  assign int_wb_data_o  = int_wb_valid_o ? result_q : {XLEN{1'b0}};

  assign fflags_o  = fflags_q;
  assign illegal_o = illegal_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl: a driver issues ops and queues the expected
// writeback/error event; a monitor pops and compares whenever the DUT emits one.
module tb_fp_issue_ctrl;

  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dec_valid_i, dec_illegal_i, dec_regwrite_i;
  logic [4:0]  dec_rd_i;
  logic        dec_ready_o, fpu_in_valid_o, fpu_in_ready_i;
  logic        fpu_out_valid_i, fpu_out_ready_o;
  logic [31:0] fpu_result_i;
  logic [4:0]  fpu_status_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        int_wb_valid_o;
  logic [31:0] int_wb_data_o;
  logic [4:0]  fflags_o;
  logic        fflags_clr_i, illegal_o, timeout_o, busy_o;

  fp_issue_ctrl #(.TIMEOUT(TMO), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dec_valid_i(dec_valid_i), .dec_illegal_i(dec_illegal_i),
    .dec_regwrite_i(dec_regwrite_i), .dec_rd_i(dec_rd_i), .dec_ready_o(dec_ready_o),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .int_wb_valid_o(int_wb_valid_o), .int_wb_data_o(int_wb_data_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .illegal_o(illegal_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Event kinds: 0 = FP regfile write, 1 = integer writeback, 2 = illegal, 3 = timeout
  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Monitor: every DUT event must match the oldest queued expectation.
  always @(negedge clk_i) begin
    exp_t e;
    logic [1:0]  k;
    logic [4:0]  a;
    logic [31:0] d;
    if (!rf_we_o) chk("rf_zero_outside_wb", {22'd0, rf_waddr_o} | rf_wdata_o, 32'd0);
    if (!int_wb_valid_o) chk("int_zero_outside_wb", int_wb_data_o, 32'd0);
    if (rf_we_o | int_wb_valid_o | illegal_o | timeout_o) begin
      k = rf_we_o ? 2'd0 : int_wb_valid_o ? 2'd1 : illegal_o ? 2'd2 : 2'd3;
      a = rf_we_o ? rf_waddr_o : 5'd0;
      d = rf_we_o ? rf_wdata_o : int_wb_valid_o ? int_wb_data_o : 32'd0;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected: got event kind %0d data 0x%0h, want no event", k, d);
      end else begin
        e = sb.pop_front();
        chk("sb_kind", {30'd0, k}, {30'd0, e.kind});
        chk("sb_addr", {27'd0, a}, {27'd0, e.addr});
        chk("sb_data", d, e.data);
      end
    end
  end

  // in_dly: ISSUE cycles until in_ready; out_dly: EXEC cycles until out_valid (0 = never)
  task automatic run_op(input logic ill, input logic rw, input logic [4:0] rd,
                        input int in_dly, input int out_dly,
                        input logic [31:0] res, input logic [4:0] st, input logic clr_wb);
    exp_t e;
    int busy_cnt = 0;
    int inv_cnt  = 0;
    chk("ready_in_idle", {31'd0, dec_ready_o}, 32'd1);
    e.kind = ill ? 2'd2 : (out_dly == 0) ? 2'd3 : rw ? 2'd0 : 2'd1;
    e.addr = (!ill && out_dly != 0 && rw) ? rd : 5'd0;
    e.data = (!ill && out_dly != 0) ? res : 32'd0;
    sb.push_back(e);
    dec_valid_i = 1'b1; dec_illegal_i = ill; dec_regwrite_i = rw; dec_rd_i = rd;
    @(negedge clk_i);
    dec_valid_i = 1'b0; dec_illegal_i = 1'b0;
    if (ill) begin
      chk("illegal_no_in_valid", {31'd0, fpu_in_valid_o}, 32'd0);
      chk("illegal_not_busy", {31'd0, busy_o}, 32'd0);
      return;
    end
    for (int c = 1; c <= in_dly; c++) begin
      inv_cnt  += int'(fpu_in_valid_o);
      busy_cnt += int'(busy_o);
      fpu_in_ready_i = (c == in_dly);
      @(negedge clk_i);
    end
    fpu_in_ready_i = 1'b0;
    chk("in_valid_cycles", inv_cnt, in_dly);
    chk("out_ready_in_exec", {31'd0, fpu_out_ready_o}, 32'd1);
    for (int c = 1; c <= ((out_dly == 0) ? TMO : out_dly); c++) begin
      busy_cnt += int'(busy_o);
      fpu_out_valid_i = (out_dly != 0) && (c == out_dly);
      fpu_result_i = res; fpu_status_i = st;
      @(negedge clk_i);
    end
    fpu_out_valid_i = 1'b0;
    if (out_dly != 0) begin
      chk("wb_strobe", {31'd0, rf_we_o | int_wb_valid_o}, 32'd1);
      busy_cnt += int'(busy_o);
      fflags_clr_i = clr_wb;
      @(negedge clk_i);
      fflags_clr_i = 1'b0;
      chk("busy_cycles", busy_cnt, in_dly + out_dly + 1);
    end else begin
      chk("busy_cycles_tmo", busy_cnt, in_dly + TMO);
    end
    chk("idle_after_op", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    dec_valid_i = 1'b0; dec_illegal_i = 1'b0; dec_regwrite_i = 1'b0; dec_rd_i = 5'd0;
    fpu_in_ready_i = 1'b0; fpu_out_valid_i = 1'b0;
    fpu_result_i = 32'd0; fpu_status_i = 5'd0; fflags_clr_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_dec_ready", {31'd0, dec_ready_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_fflags", {27'd0, fflags_o}, 32'd0);
    chk("rst_in_valid", {31'd0, fpu_in_valid_o}, 32'd0);
    chk("rst_out_ready", {31'd0, fpu_out_ready_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_op(1'b0, 1'b1, 5'd5, 1, 1, 32'h4040_0000, 5'h00, 1'b0);   // FADD, minimum latency
    run_op(1'b0, 1'b0, 5'd7, 4, 2, 32'h0000_0001, 5'h00, 1'b0);   // FLT, slow in_ready
    run_op(1'b1, 1'b1, 5'd2, 1, 1, 32'h0, 5'h00, 1'b0);           // illegal
    run_op(1'b0, 1'b1, 5'd3, 1, 0, 32'h0, 5'h00, 1'b0);           // timeout
    run_op(1'b0, 1'b1, 5'd9, 2, 3, 32'hDEAD_BEEF, 5'h00, 1'b0);   // normal op after timeout
    run_op(1'b0, 1'b1, 5'd10, 1, TMO, 32'h1234_5678, 5'h00, 1'b0); // result on last EXEC cycle

    fflags_clr_i = 1'b1; @(negedge clk_i); fflags_clr_i = 1'b0;
    run_op(1'b0, 1'b1, 5'd1, 1, 1, 32'h1, 5'h01, 1'b0);
    chk("fflags_first", {27'd0, fflags_o}, 32'h01);
    run_op(1'b0, 1'b1, 5'd1, 1, 1, 32'h2, 5'h08, 1'b0);
    chk("fflags_accum", {27'd0, fflags_o}, 32'h09);
    fflags_clr_i = 1'b1; @(negedge clk_i); fflags_clr_i = 1'b0;
    chk("fflags_clr_alone", {27'd0, fflags_o}, 32'h00);
    run_op(1'b0, 1'b0, 5'd1, 1, 1, 32'h3, 5'h01, 1'b0);
    run_op(1'b0, 1'b0, 5'd1, 1, 1, 32'h4, 5'h08, 1'b1);
    chk("fflags_clr_in_wb", {27'd0, fflags_o}, 32'h08);

    // Reset while in EXEC; a late result must be ignored.
    dec_valid_i = 1'b1; dec_regwrite_i = 1'b1; dec_rd_i = 5'd4;
    @(negedge clk_i);
    dec_valid_i = 1'b0; fpu_in_ready_i = 1'b1;
    @(negedge clk_i);
    fpu_in_ready_i = 1'b0;
    chk("pre_rst_exec", {31'd0, fpu_out_ready_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_exec_ready", {31'd0, dec_ready_o}, 32'd0);
    chk("rst_exec_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_exec_fflags", {27'd0, fflags_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    fpu_out_valid_i = 1'b1; fpu_result_i = 32'hFFFF_0000; fpu_status_i = 5'h1F;
    @(negedge clk_i);
    chk("post_rst_ready", {31'd0, dec_ready_o}, 32'd1);
    chk("post_rst_out_ready", {31'd0, fpu_out_ready_o}, 32'd0);
    @(negedge clk_i);
    fpu_out_valid_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_fflags", {27'd0, fflags_o}, 32'd0);
    chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_issue_ctrl.md
FP_ISSUE_CTRL -- requirements
Module: fp_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles in EXEC before abort (1..255).
REQ-002 SHALL have parameter XLEN, default 32, result width.
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dec_valid_i  input  1  decoded FP instruction present.
REQ-006 SHALL have port dec_illegal_i  input  1  decoded instruction illegal.
REQ-007 SHALL have port dec_regwrite_i  input  1  result targets FP register file, else integer file.
REQ-008 SHALL have port dec_rd_i  input  5  destination register.
REQ-009 SHALL have port dec_ready_o  output  1  instruction accepted this cycle; core stalls on valid & ~ready.
REQ-010 SHALL have port fpu_in_valid_o  output  1  operation request to FPU.
REQ-011 SHALL have port fpu_in_ready_i  input  1  FPU accepts request.
REQ-012 SHALL have port fpu_out_valid_i  input  1  FPU result available.
REQ-013 SHALL have port fpu_out_ready_o  output  1  controller consumes result.
REQ-014 SHALL have port fpu_result_i  input  XLEN  FPU result.
REQ-015 SHALL have port fpu_status_i  input  5  FPU exception flags {NV,DZ,OF,UF,NX}.
REQ-016 SHALL have ports rf_we_o, rf_waddr_o, rf_wdata_o  output  1/5/XLEN  FP register write.
REQ-017 SHALL have ports int_wb_valid_o, int_wb_data_o  output  1/XLEN  integer-side result (compare, class, F2I, FMV.X.W).
REQ-018 SHALL have ports fflags_o  output  5  sticky flags; fflags_clr_i  input  1  clear flags.
REQ-019 SHALL have ports illegal_o, timeout_o  output  1  one-cycle error pulses; busy_o  output  1  state != IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, EXEC, WB.
REQ-021 SHALL drive dec_ready_o=1 only in IDLE; at most one operation outstanding.
REQ-022 IDLE & dec_valid_i & ~dec_illegal_i SHALL latch dec_rd_i and dec_regwrite_i and go to ISSUE next cycle.
REQ-023 IDLE & dec_valid_i & dec_illegal_i SHALL accept (ready=1), pulse illegal_o next cycle, remain IDLE, never assert fpu_in_valid_o.
REQ-024 ISSUE SHALL hold fpu_in_valid_o=1 until fpu_in_ready_i=1, then go to EXEC next cycle; in_valid SHALL not drop before handshake.
REQ-025 EXEC SHALL drive fpu_out_ready_o=1; on fpu_out_valid_i capture fpu_result_i and fpu_status_i, go to WB.
REQ-026 EXEC SHALL count cycles from 0; counter reaching TIMEOUT without out_valid SHALL pulse timeout_o, go to IDLE, no writeback.
REQ-027 out_valid in the same cycle the counter reaches TIMEOUT SHALL win: result captured, no timeout.
REQ-028 WB SHALL last exactly one cycle: rf_we_o=1 with latched rd/result if regwrite, else int_wb_valid_o=1 with result; then IDLE.
REQ-029 Minimum latency accept -> write SHALL be 3 cycles (ISSUE ready immediately, out_valid first EXEC cycle).
REQ-030 fflags_o SHALL OR in captured status in WB cycle; fflags_clr_i alone SHALL zero it; clr and WB same cycle SHALL yield exactly captured status.
REQ-031 rf_waddr_o, rf_wdata_o, int_wb_data_o SHALL be 0 outside WB.
REQ-032 fpu_out_valid_i outside EXEC SHALL be ignored (out_ready=0, no state change).

Reset
REQ-033 rst_ni low SHALL immediately force IDLE, counter 0, fflags_o 0, all outputs 0 except dec_ready_o (1 once in IDLE after reset release... held 0 while rst_ni low).
REQ-034 Reset during ISSUE/EXEC SHALL abandon the operation; no writeback or error pulse after release.

Verification
REQ-035 FADD, rd=5, regwrite=1, in_ready and out_valid immediate, result 0x40400000 status 0 -> rf_we_o=1, waddr=5, wdata=0x40400000 on cycle 3, busy_o 3 cycles.
REQ-036 FLT, regwrite=0, in_ready delayed 4 cycles, result 1 -> fpu_in_valid_o held 4 cycles, int_wb_valid_o=1 data=1, rf_we_o stays 0.
REQ-037 dec_illegal_i=1 -> illegal_o one pulse, fpu_in_valid_o never 1, busy_o stays 0.
REQ-038 TIMEOUT=8, out_valid never -> timeout_o pulses after 8 EXEC cycles, IDLE, no write; second op then completes normally.
REQ-039 Op status 0x01 then op status 0x08 -> fflags_o=0x09; fflags_clr_i in second WB cycle -> 0x08.
REQ-040 rst_ni low in EXEC, out_valid after release -> ignored, fflags_o=0, no write, dec_ready_o=1.
